sram_bus_arbiter: RTL
=====================

// Module: sram_bus_arbiter
// PURPOSE
//  - Shares the two off-chip SRAMs (BaseRAM, ExtRAM) between the IF-stage instruction port and the MEM-stage data port.
//  - Sits between the pipeline stages and the board SRAM pins.
//  - Arbitrates one transaction at a time and sequences SRAM strobes through a fixed-latency FSM.
//  - Returns a one-cycle ack plus read data to the winning requester.
// PARAMETERS
//  WAIT_CYCLES      2   cycles spent in ACCESS (strobe width); legal 1..15
//  BANK_SEL_BIT     22  address bit choosing bank: 0=BaseRAM, 1=ExtRAM
//  MAX_DATA_STREAK  4   consecutive data grants allowed while inst waits (only with INST_STARVE_GUARD_EN)
// PORTS
//  clk            in    1   system clock
//  reset          in    1   synchronous, active-high reset
//  inst_req       in    1   IF fetch request; held high until inst_ack
//  inst_addr      in    32  fetch byte address
//  inst_rdata     out   32  fetched word; valid on inst_ack, held until next inst_ack
//  inst_ack       out   1   one-cycle completion pulse
//  data_req       in    1   MEM request; held high until data_ack
//  data_we        in    4   byte write strobes; 4'b0000 = read
//  data_addr      in    32  data byte address
//  data_wdata     out/in 32 (in) store data
//  data_rdata     out   32  load word; valid on data_ack, held until next data_ack
//  data_ack       out   1   one-cycle completion pulse
//  busy           out   1   FSM not in IDLE
//  base_ram_data  inout 32  BaseRAM data bus
//  base_ram_addr  out   20  BaseRAM word address
//  base_ram_be_n  out   4   byte enables, active low
//  base_ram_ce_n/oe_n/we_n  out 1 each  chip select / output enable / write enable, active low
//  ext_ram_*      same set as base_ram_* for ExtRAM
// BEHAVIOUR
//  - Reset values: acks=0, rdata=0, busy=0, all *_ce_n/oe_n/we_n=1, be_n=4'hF, addr=0, data buses 'z'. State=IDLE.
//  - Word address = addr[21:2]. Bank = addr[BANK_SEL_BIT]. addr[1:0] ignored.
//  - FSM states:
//    - IDLE: sample reqs.
//      - Data wins when both requesters are high (older instruction).
//      - On a grant, latch port id, bank, addr, we, wdata -> SETUP. No request -> stay.
//    - SETUP (1 cycle): drive addr and ce_n=0 on the selected bank.
//      - Read: oe_n=0, be_n=0.
//      - Write: be_n=~we, drive wdata onto the bus.
//      - -> ACCESS.
//    - ACCESS (WAIT_CYCLES cycles, 4-bit counter): strobes held; write also has we_n=0.
//      - Read data is registered from the bank bus at the clock edge ending the last ACCESS cycle.
//      - -> DONE.
//    - DONE (1 cycle): we_n=1, oe_n=1, ce_n=1.
//      - Write data still driven for hold time.
//      - Ack of the granted port = 1.
//      - -> IDLE.
//  - Latency: grant at IDLE edge T; ack is high in cycle T+2+WAIT_CYCLES. Throughput is one access per WAIT_CYCLES+3 cycles.
//  - Requesters drop or replace req in the cycle after ack. IDLE re-arbitrates on live req; no req is ever sampled outside IDLE.
//  - Request changes while not granted: ignored until IDLE.
//  - Unselected bank: all strobes 1, bus 'z', addr holds last value.
//  - Only one bank is ever active; the bus is never driven during a read or in IDLE.
//  - Read data is not retained for the non-granted port (its rdata is unchanged).
//  - Reset mid-operation: immediate IDLE, strobes released, bus 'z', no ack for the aborted transaction, rdata cleared.
//  - Simultaneous reqs to different banks: still serialized (data first).
// CONFIGURATION
//  INST_STARVE_GUARD_EN
//  - Defined: 3-bit streak counter increments on each data grant made while inst_req=1.
//    - When it equals MAX_DATA_STREAK, the next IDLE arbitration grants inst even if data_req=1.
//    - Any inst grant or an IDLE with inst_req=0 clears the counter.
//  - Undefined: strict data priority; counter absent.
// TESTING
//  1. Base read: inst_req=1, inst_addr=0x8000_0010, BaseRAM[4]=0x1234_5678, W=2 -> base_ram_addr=0x4, oe_n low 3 cycles; inst_ack in cycle T+4; inst_rdata=0x1234_5678.
//  2. Ext byte write: data_we=4'b0010, data_addr=0x8040_0008, wdata=0xAABB_CCDD -> ext_ram_be_n=4'b1101, we_n low exactly W cycles, addr=0x2; base strobes stay high.
//  3. Contention: inst_req and data_req high in the same cycle -> data_ack first; inst_ack WAIT_CYCLES+3 cycles later.
//  4. Reset in ACCESS cycle 1 of a write -> next cycle all strobes=1, bus 'z', no ack, busy=0.
//  5. Starvation (macro on, MAX=4): data_req held continuously with inst_req=1 -> 4 data_acks, then inst_ack, then data resumes.
//  6. Back-to-back: after a data read ack, present a new data read the next cycle -> granted with no extra idle cycle; the bus is never driven in a read.

Source files
------------

// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: shares BaseRAM/ExtRAM between the instruction fetch port
// and the data port. One transaction at a time, sequenced IDLE -> SETUP ->
// ACCESS (WAIT_CYCLES) -> DONE, with a one-cycle ack to the winning port.
// Optional feature macro: INST_STARVE_GUARD_EN (bounds consecutive data grants
// while an instruction fetch is waiting).
module sram_bus_arbiter #(
    parameter int unsigned WAIT_CYCLES  = 2,
    parameter int unsigned BANK_SEL_BIT = 22
`ifdef INST_STARVE_GUARD_EN
    ,
    parameter int unsigned MAX_DATA_STREAK = 4
`endif
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        inst_ack,

    input  logic        data_req,
    input  logic [3:0]  data_we,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_ack,

    output logic        busy,

    inout  wire  [31:0] base_ram_data,
    output logic [19:0] base_ram_addr,
    output logic [3:0]  base_ram_be_n,
    output logic        base_ram_ce_n,
    output logic        base_ram_oe_n,
    output logic        base_ram_we_n,

    inout  wire  [31:0] ext_ram_data,
    output logic [19:0] ext_ram_addr,
    output logic [3:0]  ext_ram_be_n,
    output logic        ext_ram_ce_n,
    output logic        ext_ram_oe_n,
    output logic        ext_ram_we_n
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              port_q, port_d;       // 1 = data port owns the transaction
    logic              bank_q, bank_d;       // 1 = ExtRAM
    logic [19:0]       waddr_q, waddr_d;
    logic [3:0]        we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;

    logic              grant_data, grant_inst, force_inst;
    logic              is_wr, active;
    logic              capture;
    logic [31:0]       bank_rdata;

    logic              inst_ack_d, data_ack_d, busy_d;
    logic [31:0]       inst_rdata_d, data_rdata_d;
    logic [19:0]       base_addr_d, ext_addr_d;
    logic [3:0]        base_be_n_d, ext_be_n_d;
    logic              base_ce_n_d, base_oe_n_d, base_we_n_d, base_drv_d, base_drv_q;
    logic              ext_ce_n_d, ext_oe_n_d, ext_we_n_d, ext_drv_d, ext_drv_q;

    // Only the word address and bank bit of the byte addresses are meaningful.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{inst_addr, data_addr};

    // Bank data buses are driven only while a write owns that bank.
    assign base_ram_data = base_drv_q ? wdata_q : 32'bz;
    assign ext_ram_data  = ext_drv_q  ? wdata_q : 32'bz;

    assign bank_rdata = bank_q ? ext_ram_data : base_ram_data;

    // Next-state, latched transaction fields and next registered pin values.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        port_d     = port_q;
        bank_d     = bank_q;
        waddr_d    = waddr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        grant_data = 1'b0;
        grant_inst = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (data_req && !force_inst) begin
                    grant_data = 1'b1;
                end else if (inst_req) begin
                    grant_inst = 1'b1;
                end
                if (grant_data) begin
                    port_d  = 1'b1;
                    bank_d  = data_addr[BANK_SEL_BIT];
                    waddr_d = data_addr[21:2];
                    we_d    = data_we;
                    wdata_d = data_wdata;
                    state_d = S_SETUP;
                end else if (grant_inst) begin
                    port_d  = 1'b0;
                    bank_d  = inst_addr[BANK_SEL_BIT];
                    waddr_d = inst_addr[21:2];
                    we_d    = 4'h0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                cnt_d   = '0;
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Pin values for the state being entered, so pins change with the state.
        is_wr  = (we_d != 4'h0);
        active = (state_d == S_SETUP) || (state_d == S_ACCESS);

        base_ce_n_d = 1'b1;
        base_oe_n_d = 1'b1;
        base_we_n_d = 1'b1;
        base_be_n_d = 4'hF;
        base_drv_d  = 1'b0;
        base_addr_d = base_ram_addr;
        ext_ce_n_d  = 1'b1;
        ext_oe_n_d  = 1'b1;
        ext_we_n_d  = 1'b1;
        ext_be_n_d  = 4'hF;
        ext_drv_d   = 1'b0;
        ext_addr_d  = ext_ram_addr;

        if (!bank_d) begin
            base_ce_n_d = !active;
            base_oe_n_d = !(active && !is_wr);
            base_we_n_d = !((state_d == S_ACCESS) && is_wr);
            base_be_n_d = active ? (is_wr ? ~we_d : 4'h0) : 4'hF;
            base_drv_d  = is_wr && (active || (state_d == S_DONE));
            if (active) begin
                base_addr_d = waddr_d;
            end
        end else begin
            ext_ce_n_d = !active;
            ext_oe_n_d = !(active && !is_wr);
            ext_we_n_d = !((state_d == S_ACCESS) && is_wr);
            ext_be_n_d = active ? (is_wr ? ~we_d : 4'h0) : 4'hF;
            ext_drv_d  = is_wr && (active || (state_d == S_DONE));
            if (active) begin
                ext_addr_d = waddr_d;
            end
        end

        inst_ack_d = (state_d == S_DONE) && !port_d;
        data_ack_d = (state_d == S_DONE) && port_d;
        busy_d     = (state_d != S_IDLE);

        // Read data is taken at the edge that closes the last ACCESS cycle.
        capture      = (state_q == S_ACCESS) && (cnt_q == LAST_CNT) && (we_q == 4'h0);
        inst_rdata_d = inst_rdata;
        data_rdata_d = data_rdata;
        if (capture && !port_q) begin
            inst_rdata_d = bank_rdata;
        end
        if (capture && port_q) begin
            data_rdata_d = bank_rdata;
        end
    end

    // State, transaction fields and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            port_q        <= 1'b0;
            bank_q        <= 1'b0;
            waddr_q       <= '0;
            we_q          <= '0;
            wdata_q       <= '0;
            inst_ack      <= 1'b0;
            data_ack      <= 1'b0;
            inst_rdata    <= '0;
            data_rdata    <= '0;
            busy          <= 1'b0;
            base_ram_addr <= '0;
            base_ram_be_n <= 4'hF;
            base_ram_ce_n <= 1'b1;
            base_ram_oe_n <= 1'b1;
            base_ram_we_n <= 1'b1;
            base_drv_q    <= 1'b0;
            ext_ram_addr  <= '0;
            ext_ram_be_n  <= 4'hF;
            ext_ram_ce_n  <= 1'b1;
            ext_ram_oe_n  <= 1'b1;
            ext_ram_we_n  <= 1'b1;
            ext_drv_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            port_q        <= port_d;
            bank_q        <= bank_d;
            waddr_q       <= waddr_d;
            we_q          <= we_d;
            wdata_q       <= wdata_d;
            inst_ack      <= inst_ack_d;
            data_ack      <= data_ack_d;
            inst_rdata    <= inst_rdata_d;
            data_rdata    <= data_rdata_d;
            busy          <= busy_d;
            base_ram_addr <= base_addr_d;
            base_ram_be_n <= base_be_n_d;
            base_ram_ce_n <= base_ce_n_d;
            base_ram_oe_n <= base_oe_n_d;
            base_ram_we_n <= base_we_n_d;
            base_drv_q    <= base_drv_d;
            ext_ram_addr  <= ext_addr_d;
            ext_ram_be_n  <= ext_be_n_d;
            ext_ram_ce_n  <= ext_ce_n_d;
            ext_ram_oe_n  <= ext_oe_n_d;
            ext_ram_we_n  <= ext_we_n_d;
            ext_drv_q     <= ext_drv_d;
        end
    end

`ifdef INST_STARVE_GUARD_EN
    logic [2:0] streak_q, streak_d;

    assign force_inst = inst_req && (streak_q == 3'(MAX_DATA_STREAK));

    // Count data grants that overtook a waiting fetch; cleared once inst is served or absent.
    always_comb begin
        streak_d = streak_q;
        if (state_q == S_IDLE) begin
            if (!inst_req || grant_inst) begin
                streak_d = '0;
            end else if (grant_data) begin
                streak_d = streak_q + 3'd1;
            end
        end
    end

    // Streak counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end
`else
    assign force_inst = 1'b0;
`endif

endmodule
